// File: rtl/prim_subreg_upd_arb.sv
// Round-robin arbiter sharing one SwAccessRW subreg among N HW updaters; SW-collided updates are re-merged and retried.
// Optional starvation flag behind macro PRIM_SUBREG_UPD_ARB_STARVE_EN (undefined: starve_o tied 0).
module prim_subreg_upd_arb #(
  parameter int N        = 4,
  parameter int DW       = 32,
  parameter int MaxRetry = 15
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N-1:0]    req_i,
  input  logic [N*DW-1:0] data_i,
  input  logic [N*DW-1:0] mask_i,
  output logic [N-1:0]    gnt_o,
  output logic [N-1:0]    done_o,
  output logic            busy_o,
  input  logic            sw_we_i,
  input  logic [DW-1:0]   q_i,
  output logic            de_o,
  output logic [DW-1:0]   d_o,
  output logic            starve_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   id_q, id_d;
  logic [DW-1:0]   data_q, data_d;
  logic [DW-1:0]   mask_q, mask_d;
  logic [IW-1:0]   winner;
  logic            found;
  logic            issue;
  int              idx;

  // First requester at or above rr_ptr, wrapping N-1 -> 0.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req_i[idx]) begin
        found  = 1'b1;
        winner = idx[IW-1:0];
      end
    end
  end

  assign issue = (state_q == ISSUE);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    data_d   = data_q;
    mask_d   = mask_q;
    gnt_o    = '0;
    done_o   = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_o[winner] = 1'b1;
          id_d          = winner;
          data_d        = data_i[winner*DW +: DW];
          mask_d        = mask_i[winner*DW +: DW];
          rr_ptr_d      = (winner == IW'(N-1)) ? '0 : winner + 1'b1;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        // A SW write in this cycle wins the subreg; stay and re-merge against the new q_i.
        if (!sw_we_i) begin
          done_o[id_q] = rst_ni;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = issue;
  assign de_o   = issue;
  assign d_o    = issue ? ((q_i & ~mask_q) | (data_q & mask_q)) : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      data_q   <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
    end
  end

`ifdef PRIM_SUBREG_UPD_ARB_STARVE_EN
  localparam int RW = $clog2(MaxRetry + 1);

  logic [RW-1:0] retry_cnt_q, retry_cnt_d;

  always_comb begin
    retry_cnt_d = retry_cnt_q;
    if (!issue && found) begin
      retry_cnt_d = '0;
    end else if (issue && sw_we_i && (retry_cnt_q != RW'(MaxRetry))) begin
      retry_cnt_d = retry_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) retry_cnt_q <= '0;
    else         retry_cnt_q <= retry_cnt_d;
  end

  assign starve_o = issue && (retry_cnt_q == RW'(MaxRetry));
`else
  assign starve_o = 1'b0;
`endif

endmodule

// File: tb/tb_prim_subreg_upd_arb.sv
// Directed bench for prim_subreg_upd_arb with a scoreboard of expected commits (id one-hot, merged data).
module tb_prim_subreg_upd_arb;

  localparam int N  = 4;
  localparam int DW = 32;
`ifdef PRIM_SUBREG_UPD_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [N-1:0]    req_i;
  logic [N*DW-1:0] data_i;
  logic [N*DW-1:0] mask_i;
  logic [N-1:0]    gnt_o;
  logic [N-1:0]    done_o;
  logic            busy_o;
  logic            sw_we_i;
  logic [DW-1:0]   q_i;
  logic            de_o;
  logic [DW-1:0]   d_o;
  logic            starve_o;

  prim_subreg_upd_arb #(.N(N), .DW(DW), .MaxRetry(3)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .data_i(data_i), .mask_i(mask_i),
    .gnt_o(gnt_o), .done_o(done_o), .busy_o(busy_o), .sw_we_i(sw_we_i), .q_i(q_i),
    .de_o(de_o), .d_o(d_o), .starve_o(starve_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [N-1:0]  done;
    logic [DW-1:0] d;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk_i);
    #2;
  endtask

  task automatic set_slot(input int k, input logic [DW-1:0] d, input logic [DW-1:0] m);
    data_i[k*DW +: DW] = d;
    mask_i[k*DW +: DW] = m;
  endtask

  task automatic push(input int k, input logic [DW-1:0] d);
    exp_t e;
    e.done    = '0;
    e.done[k] = 1'b1;
    e.d       = d;
    sb.push_back(e);
  endtask

  task automatic commit(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(done_o), 64'hdead);
    end else begin
      e = sb.pop_front();
      chk({tag, "_done"}, 64'(done_o), 64'(e.done));
      chk({tag, "_d"}, 64'(d_o), 64'(e.d));
      chk({tag, "_de"}, 64'(de_o), 64'd1);
    end
  endtask

  initial begin
    rst_ni = 1'b0; req_i = '0; data_i = '0; mask_i = '0; sw_we_i = 1'b0; q_i = '0;
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    #1;
    chk("rst_gnt", 64'(gnt_o), 0);
    chk("rst_done", 64'(done_o), 0);
    chk("rst_busy", 64'(busy_o), 0);
    chk("rst_de", 64'(de_o), 0);
    chk("rst_d", 64'(d_o), 0);
    chk("rst_starve", 64'(starve_o), 0);

    // Single request
    next_cyc();
    req_i = 4'b0010; set_slot(1, 32'hA5, 32'hFF); q_i = 32'h1234_0000;
    #1;
    chk("single_gnt", 64'(gnt_o), 64'b0010);
    chk("single_busy_c", 64'(busy_o), 0);
    push(1, 32'h1234_00A5);
    next_cyc();
    req_i = '0;
    #1;
    chk("single_busy", 64'(busy_o), 1);
    chk("single_gnt_busy", 64'(gnt_o), 0);
    commit("single");
    next_cyc();
    #1;
    chk("single_idle", 64'(busy_o), 0);

    // Round robin from rr_ptr=0
    rst_ni = 1'b0;
    next_cyc();
    rst_ni = 1'b1;
    for (int k = 0; k < N; k++) set_slot(k, 32'h10 + k, 32'hFFFF_FFFF);
    q_i = '0; req_i = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      #1;
      chk($sformatf("rr_gnt%0d", g), 64'(gnt_o), 64'(1 << (g % N)));
      push(g % N, 32'h10 + (g % N));
      next_cyc();
      #1;
      chk($sformatf("rr_nogrant%0d", g), 64'(gnt_o), 0);
      commit($sformatf("rr%0d", g));
      next_cyc();
    end
    req_i = '0;

    // SW collision then retry against updated q_i
    set_slot(3, 32'hFFFF_FFFF, 32'hF); q_i = '0; req_i = 4'b1000;
    #1;
    chk("col_gnt", 64'(gnt_o), 64'b1000);
    push(3, 32'hF000_000F);
    next_cyc();
    req_i = '0; sw_we_i = 1'b1;
    #1;
    chk("col_de", 64'(de_o), 1);
    chk("col_nodone", 64'(done_o), 0);
    chk("col_d0", 64'(d_o), 64'h0000_000F);
    next_cyc();
    sw_we_i = 1'b0; q_i = 32'hF000_0000;
    #1;
    commit("col");
    next_cyc();

    // Starvation with MaxRetry=3
    set_slot(0, 32'h1234, 32'hFFFF); q_i = '0; req_i = 4'b0001;
    #1;
    chk("stv_gnt", 64'(gnt_o), 64'b0001);
    push(0, 32'h0000_1234);
    next_cyc();
    req_i = '0; sw_we_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("stv_flag%0d", i), 64'(starve_o), 64'(STARVE_ON && (i == 3)));
      chk($sformatf("stv_nodone%0d", i), 64'(done_o), 0);
      next_cyc();
    end
    sw_we_i = 1'b0;
    #1;
    chk("stv_flag_commit", 64'(starve_o), 64'(STARVE_ON));
    commit("stv");
    next_cyc();
    #1;
    chk("stv_clear", 64'(starve_o), 0);
    chk("stv_idle", 64'(busy_o), 0);

    // Reset while in ISSUE
    set_slot(1, 32'h77, 32'hFF); req_i = 4'b0010;
    #1;
    chk("rmid_gnt", 64'(gnt_o), 64'b0010);
    next_cyc();
    req_i = '0; sw_we_i = 1'b1; rst_ni = 1'b0;
    #1;
    chk("rmid_de_before", 64'(de_o), 1);
    next_cyc();
    rst_ni = 1'b1; sw_we_i = 1'b0; req_i = 4'b1111; set_slot(0, 32'hAB, 32'hFF); q_i = '0;
    #1;
    chk("rmid_de", 64'(de_o), 0);
    chk("rmid_busy", 64'(busy_o), 0);
    chk("rmid_done", 64'(done_o), 0);
    chk("rmid_first_gnt", 64'(gnt_o), 64'b0001);
    push(0, 32'hAB);
    next_cyc();
    req_i = '0;
    #1;
    commit("rmid");
    next_cyc();

    // Withdrawn request while busy, plus mask=0 update
    set_slot(1, 32'hFFFF, 32'h0); q_i = 32'h5555; req_i = 4'b0010;
    #1;
    chk("wd_gnt", 64'(gnt_o), 64'b0010);
    push(1, 32'h5555);
    next_cyc();
    req_i = 4'b0100; sw_we_i = 1'b1;
    #1;
    chk("wd_gnt_busy", 64'(gnt_o), 0);
    next_cyc();
    req_i = '0; sw_we_i = 1'b0;
    #1;
    chk("wd_gnt_busy2", 64'(gnt_o), 0);
    commit("wd_mask0");
    next_cyc();
    #1;
    chk("wd_never_gnt", 64'(gnt_o), 0);
    chk("wd_no_done", 64'(done_o), 0);
    chk("sb_drained", 64'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
